// File: rtl/vga_console_writer.sv
// Character console writer for an 80x60 text RAM: interprets a byte stream
// (printables, LF, CR, BS, FF) into cell writes and maintains the cursor.
module vga_console_writer #(
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ch_in,
  input  logic        ch_valid,
  output logic        ch_ready,
  output logic        we,
  output logic [12:0] waddr,
  output logic [7:0]  wdata,
  output logic [5:0]  cur_row,
  output logic [6:0]  cur_col
);

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_LINE} state_t;

  localparam logic [12:0] LAST_CELL = 13'd4799;
  localparam logic [6:0]  LAST_COL  = 7'd79;
  localparam logic [5:0]  LAST_ROW  = 6'd59;

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [5:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic        we_q, we_d;
  logic [12:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        adv_row;

  // row*80 + col as row*64 + row*16 + col
  function automatic logic [12:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
    return {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {6'b0, col};
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    col_d    = col_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    adv_row  = 1'b0;
    ch_ready = (state_q == IDLE);

    case (state_q)
      CLEAR_ALL: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = BLANK;
        if (cnt_q == LAST_CELL) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end

      CLEAR_LINE: begin
        we_d    = 1'b1;
        waddr_d = cell_addr(row_q, cnt_q[6:0]);
        wdata_d = BLANK;
        if (cnt_q[6:0] == LAST_COL) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end

      IDLE: begin
        if (ch_valid) begin
          if (ch_in >= 8'h20 && ch_in <= 8'h7E) begin
            we_d    = 1'b1;
            waddr_d = cell_addr(row_q, col_q);
            wdata_d = ch_in;
            if (col_q == LAST_COL) begin
              col_d   = '0;
              adv_row = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else begin
            case (ch_in)
              8'h0A: begin
                col_d   = '0;
                adv_row = 1'b1;
              end
              8'h0D: col_d = '0;
              8'h08: begin
                if (col_q != 7'd0) begin
                  col_d   = col_q - 7'd1;
                  we_d    = 1'b1;
                  waddr_d = cell_addr(row_q, col_q - 7'd1);
                  wdata_d = BLANK;
                end
              end
              8'h0C: begin
                state_d = CLEAR_ALL;
                cnt_d   = '0;
                row_d   = '0;
                col_d   = '0;
              end
              default: ;
            endcase
          end
        end
      end

      default: begin
        state_d = CLEAR_ALL;
        cnt_d   = '0;
      end
    endcase

    // Wrapping off the bottom row scrolls nothing; it blanks row 0 for reuse.
    if (adv_row) begin
      if (row_q == LAST_ROW) begin
        row_d   = '0;
        state_d = CLEAR_LINE;
        cnt_d   = '0;
      end else begin
        row_d = row_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ALL;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= BLANK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we      = we_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign cur_row = row_q;
  assign cur_col = col_q;

endmodule

// File: tb/tb_vga_console_writer.sv
// Bench for vga_console_writer: directed scenarios plus random character
// traffic, checked against a cursor/expected-write model of the console rules.
module tb_vga_console_writer;

  localparam int LIM = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ch_in;
  logic        ch_valid;
  logic        ch_ready;
  logic        we;
  logic [12:0] waddr;
  logic [7:0]  wdata;
  logic [5:0]  cur_row;
  logic [6:0]  cur_col;

  vga_console_writer #(.BLANK(8'h20)) dut (
    .clk(clk), .rst(rst), .ch_in(ch_in), .ch_valid(ch_valid),
    .ch_ready(ch_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .cur_row(cur_row), .cur_col(cur_col)
  );

  always #20 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_q[$];
  bit mon_en   = 1'b0;
  int last_cyc = 0, prev_cyc = 0;
  int last_addr = -1, last_data = -1;
  int mr = 0, mc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every write must be the next one the model predicts.
  always @(negedge clk) begin
    if (mon_en && we) begin
      int e;
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write addr=%0d data=%h expected none", waddr, wdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_assert++;
        assert ({19'b0, waddr, wdata} === 32'(e)) else begin
          n_fail++;
          $error("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                 waddr, wdata, e >> 8, e & 8'hFF);
        end
      end
      prev_cyc  = last_cyc;
      last_cyc  = cyc;
      last_addr = int'(waddr);
      last_data = int'(wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic void push_wr(input int a, input int d);
    exp_q.push_back((a << 8) | d);
  endfunction

  function automatic void model_adv_row();
    if (mr == 59) begin
      mr = 0;
      for (int i = 0; i < 80; i++) push_wr(i, 8'h20);
    end else begin
      mr = mr + 1;
    end
  endfunction

  function automatic void model_char(input int c);
    if (c >= 32 && c <= 126) begin
      push_wr(mr * 80 + mc, c);
      if (mc == 79) begin
        mc = 0;
        model_adv_row();
      end else begin
        mc = mc + 1;
      end
    end else if (c == 8'h0A) begin
      mc = 0;
      model_adv_row();
    end else if (c == 8'h0D) begin
      mc = 0;
    end else if (c == 8'h08) begin
      if (mc > 0) begin
        mc = mc - 1;
        push_wr(mr * 80 + mc, 8'h20);
      end
    end else if (c == 8'h0C) begin
      mr = 0;
      mc = 0;
      for (int i = 0; i < 4800; i++) push_wr(i, 8'h20);
    end
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [7:0] c, output int waited);
    waited = 0;
    ch_in = c;
    ch_valid = 1'b1;
    while (ch_ready !== 1'b1 && waited < LIM) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= LIM) begin
      chk("send_timeout", 32'(waited), 32'(0));
      ch_valid = 1'b0;
    end else begin
      model_char(int'(c));
      @(negedge clk);
      ch_valid = 1'b0;
      chk("cur_row", 32'(cur_row), 32'(mr));
      chk("cur_col", 32'(cur_col), 32'(mc));
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ch_ready !== 1'b1 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) chk("ready_timeout", 32'(n), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"},    32'(we),       32'(0));
    chk({tag, "_waddr"}, 32'(waddr),    32'(0));
    chk({tag, "_wdata"}, 32'(wdata),    32'(8'h20));
    chk({tag, "_ready"}, 32'(ch_ready), 32'(0));
    chk({tag, "_row"},   32'(cur_row),  32'(0));
    chk({tag, "_col"},   32'(cur_col),  32'(0));
  endtask

  task automatic release_reset();
    rst = 1'b0;
    mr = 0;
    mc = 0;
    for (int i = 0; i < 4800; i++) push_wr(i, 8'h20);
    mon_en = 1'b1;
  endtask

  initial begin
    int w, w2, n;
    int r, c;
    rst = 1'b1;
    ch_in = 8'h00;
    ch_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");

    // Power-up clear: ready rises exactly 4800 cycles after release.
    release_reset();
    wait_ready(n);
    chk("init_clear_cycles", 32'(n), 32'(4800));
    @(negedge clk);
    chk("init_clear_done", 32'(exp_q.size()), 32'(0));
    chk("init_cur_row", 32'(cur_row), 32'(0));
    chk("init_cur_col", 32'(cur_col), 32'(0));
    chk("init_ready", 32'(ch_ready), 32'(1));

    // Back-to-back "AB".
    send(8'h41, w);
    send(8'h42, w2);
    chk("ab_no_stall", 32'(w + w2), 32'(0));
    @(negedge clk);
    chk("ab_consecutive", 32'(last_cyc - prev_cyc), 32'(1));
    chk("ab_last_addr", 32'(last_addr), 32'(1));
    chk("ab_last_data", 32'(last_data), 32'(8'h42));

    // Move to (3,79), then 'Z' wraps to (4,0).
    send(8'h0D, w);
    repeat (3) send(8'h0A, w);
    for (int i = 0; i < 79; i++) send(8'h30 + 8'(i % 10), w);
    chk("z_pre_col", 32'(cur_col), 32'(79));
    send(8'h5A, w);
    @(negedge clk);
    chk("z_addr", 32'(last_addr), 32'(319));
    chk("z_data", 32'(last_data), 32'(8'h5A));
    chk("z_row", 32'(cur_row), 32'(4));
    chk("z_col", 32'(cur_col), 32'(0));

    // Row 59 + LF: wrap to row 0 and blank it for 80 cycles.
    repeat (55) send(8'h0A, w);
    chk("lf_pre_row", 32'(cur_row), 32'(59));
    send(8'h0A, w);
    wait_ready(n);
    chk("lf_busy_cycles", 32'(n), 32'(80));
    @(negedge clk);
    chk("lf_clear_done", 32'(exp_q.size()), 32'(0));
    chk("lf_last_addr", 32'(last_addr), 32'(79));

    // Backspace at (2,5) and at column 0.
    send(8'h0A, w);
    send(8'h0A, w);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), w);
    send(8'h08, w);
    @(negedge clk);
    chk("bs_addr", 32'(last_addr), 32'(164));
    chk("bs_data", 32'(last_data), 32'(8'h20));
    chk("bs_col", 32'(cur_col), 32'(4));
    send(8'h0D, w);
    send(8'h08, w);
    chk("bs0_no_write", 32'(we), 32'(0));
    chk("bs0_col", 32'(cur_col), 32'(0));

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      c = int'($urandom_range(32, 126));
      else if (r < 78) c = 8'h0A;
      else if (r < 84) c = 8'h0D;
      else if (r < 92) c = 8'h08;
      else begin
        case ($urandom_range(0, 4))
          0: c = 8'h00;
          1: c = 8'h1B;
          2: c = 8'h7F;
          3: c = 8'h09;
          default: c = int'($urandom_range(128, 255));
        endcase
      end
      send(8'(c), w);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("rand_writes_done", 32'(exp_q.size()), 32'(0));

    // Form feed, then reset in the middle of the full clear.
    send(8'h0C, w);
    chk("ff_not_ready", 32'(ch_ready), 32'(0));
    repeat (998) @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst1");
    release_reset();
    wait_ready(n);
    chk("abort_clear_cycles", 32'(n), 32'(4800));
    @(negedge clk);
    chk("abort_clear_done", 32'(exp_q.size()), 32'(0));
    chk("abort_last_addr", 32'(last_addr), 32'(4799));
    chk("abort_cur_row", 32'(cur_row), 32'(0));
    chk("abort_cur_col", 32'(cur_col), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
